// File: rtl/jedro_1_ram_resp_pkg.sv
// Shared types and bus constants for the jedro_1 RAM responder.
package jedro_1_ram_resp_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WAIT_MAX  = 15;
  localparam int unsigned CNT_W     = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Captured request fields; the word index lives beside it since its width is per-instance.
  typedef struct packed {
    logic              we;
    logic              err;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/jedro_1_ram_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
module jedro_1_ram_array
  import jedro_1_ram_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so the tools can map it to block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < BE_W; k++) begin
        if (be_i[k]) begin
          mem_q[index_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
    rdata_q <= mem_q[index_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jedro_1_ram_resp.sv
// Single-outstanding RAM responder on the jedro_1 req/gnt/rvalid bus.
// Define JEDRO_1_RAM_ERR_EN to report out-of-range accesses on err_o.
module jedro_1_ram_resp
  import jedro_1_ram_resp_pkg::*;
#(
  parameter int unsigned        MEM_SIZE_WORDS = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned        WAIT_CYCLES    = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rvalid_q;
  logic              err_q;
  logic              zero_q;
  logic [DATA_W-1:0] hold_q;

  logic              gnt_c;
  logic              addr_err_c;
  logic              unused_c;
  req_t              req_in_c;
  req_t              acc_c;
  logic [IDX_W-1:0]  acc_idx_c;
  logic              enter_resp_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_rdata_c;

`ifdef JEDRO_1_RAM_ERR_EN
  localparam int unsigned AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [AW1-1:0] RANGE_HI = RANGE_LO + (AW1'(MEM_SIZE_WORDS) << 2);

  assign addr_err_c = ({1'b0, addr_i} < RANGE_LO) || ({1'b0, addr_i} >= RANGE_HI);
  assign unused_c   = ^addr_i[1:0];
`else
  assign addr_err_c = 1'b0;
  assign unused_c   = ^{addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0], BASE_ADDR};
`endif

  // A grant needs the bus out of reset and the FSM ready for a new request.
  assign gnt_c = rstn_i & req_i & (state_q != ST_WAIT);
  assign gnt_o = gnt_c;

  always_comb begin
    req_in_c       = '0;
    req_in_c.we    = we_i;
    req_in_c.err   = addr_err_c;
    req_in_c.be    = be_i;
    req_in_c.wdata = wdata_i;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (gnt_c) begin
          req_d = req_in_c;
          idx_d = addr_i[IDX_W+1:2];
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-wait requests hit the array on their grant edge, so bypass the capture registers.
  assign acc_c        = (state_q == ST_WAIT) ? req_q : req_in_c;
  assign acc_idx_c    = (state_q == ST_WAIT) ? idx_q : addr_i[IDX_W+1:2];
  assign enter_resp_c = (state_d == ST_RESP);
  assign ram_we_c     = enter_resp_c & acc_c.we & ~acc_c.err;

  jedro_1_ram_array #(
    .DEPTH (MEM_SIZE_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (ram_we_c),
    .be_i    (acc_c.be),
    .index_i (acc_idx_c),
    .wdata_i (acc_c.wdata),
    .rdata_o (ram_rdata_c)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      idx_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      rvalid_q <= enter_resp_c;
      if (enter_resp_c) begin
        err_q  <= acc_c.err;
        zero_q <= acc_c.we | acc_c.err;
      end
      if (rvalid_q) begin
        hold_q <= rdata_o;
      end
    end
  end

  // Writes and errors answer with zero; between responses the last value is held.
  assign rdata_o  = rvalid_q ? (zero_q ? '0 : ram_rdata_c) : hold_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_jedro_1_ram_resp.sv
// Bench for jedro_1_ram_resp: three instances (0, 3 and 5 wait states) against a word-array model.
module tb_jedro_1_ram_resp;

  localparam int unsigned ND = 3;
  localparam int unsigned WC [ND] = '{0, 3, 5};
`ifdef JEDRO_1_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn   [ND];
  logic        req    [ND];
  logic        we     [ND];
  logic [3:0]  be     [ND];
  logic [31:0] addr   [ND];
  logic [31:0] wdata  [ND];
  logic        gnt    [ND];
  logic        rvalid [ND];
  logic [31:0] rdata  [ND];
  logic        err    [ND];

  logic [31:0] mdl [ND][1024];
  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    jedro_1_ram_resp #(
      .MEM_SIZE_WORDS (1024),
      .BASE_ADDR      (32'h0000_0000),
      .WAIT_CYCLES    (WC[g])
    ) u_dut (
      .clk_i    (clk),
      .rstn_i   (rstn[g]),
      .req_i    (req[g]),
      .we_i     (we[g]),
      .be_i     (be[g]),
      .addr_i   (addr[g]),
      .wdata_i  (wdata[g]),
      .gnt_o    (gnt[g]),
      .rvalid_o (rvalid[g]),
      .rdata_o  (rdata[g]),
      .err_o    (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: range/alias rule, byte merge on write, zero data on write or error.
  function automatic void model(input int d, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] er, output logic ee);
    int idx;
    idx = int'((a / 4) % 1024);
    if (ERR_EN && (a >= 32'h1000)) begin
      ee = 1'b1;
      er = '0;
    end else begin
      ee = 1'b0;
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
        er = '0;
      end else begin
        er = mdl[d][idx];
      end
    end
  endfunction

  // One complete transaction; caller starts just after a falling edge.
  task automatic txn(input int d, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] er;
    logic        ee;
    int          k;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    #1;
    k = 0;
    while (!gnt[d] && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check("gnt", 32'(gnt[d]), 32'd1);
    model(d, w, b, a, wd, er, ee);
    @(posedge clk); #1;
    req[d] = 1'b0;
    k = 1;
    @(negedge clk);
    while (!rvalid[d] && k < 40) begin
      @(negedge clk); k++;
    end
    check("latency", 32'(k), 32'(WC[d] + 1));
    check("rdata", rdata[d], er);
    check("err", 32'(err[d]), 32'(ee));
    got = rdata[d];
  endtask

  initial begin
    logic [31:0] got, prior, expw0;
    logic [31:0] a4 [4];
    int          pulses;

    for (int d = 0; d < ND; d++) begin
      rstn[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
    end

    // Reset and idle.
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) rstn[d] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        check("rst_rvalid", 32'(rvalid[d]), 32'd0);
        check("rst_rdata", rdata[d], 32'd0);
        check("rst_gnt", 32'(gnt[d]), 32'd0);
      end
    end

    // Fill a window of words so later reads have known contents.
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 64; i++)
        txn(d, 1'b1, 4'hF, 32'(i * 4), $urandom, got);

    // Byte-enabled write then read.
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, got);
    txn(0, 1'b1, 4'h1, 32'h10, 32'h000000AA, got);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, got);
    check("be_merge", got, 32'hDEADBEAA);

    // Wait states: request held through WAIT is re-granted only in RESP.
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
    #1;
    check("ws_gnt_t", 32'(gnt[1]), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      check("ws_gnt_wait", 32'(gnt[1]), 32'd0);
      check("ws_rvalid_wait", 32'(rvalid[1]), 32'd0);
    end
    @(negedge clk); #1;
    check("ws_rvalid_t4", 32'(rvalid[1]), 32'd1);
    check("ws_rdata_t4", rdata[1], mdl[1][0]);
    check("ws_regrant", 32'(gnt[1]), 32'd1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    pulses = 1;
    @(negedge clk);
    while (!rvalid[1] && pulses < 40) begin
      @(negedge clk); pulses++;
    end
    check("ws_second_lat", 32'(pulses), 32'd4);
    check("ws_second_rdata", rdata[1], mdl[1][0]);

    // Back-to-back reads at zero wait states.
    a4 = '{32'h40, 32'h44, 32'h48, 32'h4C};
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = a4[0];
    #1;
    check("b2b_gnt0", 32'(gnt[0]), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      addr[0] = a4[i];
      @(negedge clk);
      check("b2b_gnt", 32'(gnt[0]), 32'd1);
      check("b2b_rvalid", 32'(rvalid[0]), 32'd1);
      check("b2b_rdata", rdata[0], mdl[0][a4[i-1] / 4]);
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("b2b_rvalid_last", 32'(rvalid[0]), 32'd1);
    check("b2b_rdata_last", rdata[0], mdl[0][a4[3] / 4]);
    @(negedge clk);
    check("b2b_idle", 32'(rvalid[0]), 32'd0);
    check("b2b_hold", rdata[0], mdl[0][a4[3] / 4]);

    // Out of range write: error response or alias onto word 0.
    prior = mdl[0][0];
    txn(0, 1'b1, 4'hF, 32'h1000, 32'h12345678, got);
    txn(0, 1'b0, 4'hF, 32'h0, 32'h0, got);
    expw0 = ERR_EN ? prior : 32'h12345678;
    check("oor_word0", got, expw0);

    // Reset during WAIT drops the write and its response.
    prior = mdl[2][8];
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'hCAFEF00D;
    #1;
    check("rst_mid_gnt", 32'(gnt[2]), 32'd1);
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    rstn[2] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) rstn[2] = 1'b1;
      @(negedge clk);
      if (rvalid[2]) pulses++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_resp", 32'(pulses), 32'd0);
    @(negedge clk);
    txn(2, 1'b0, 4'hF, 32'h20, 32'h0, got);
    check("rst_mid_prior", got, prior);

    // Randomized traffic on every instance.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 150; n++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
        txn(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, got);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
